lf_multiword_add_seq: RTL and testbench

Multi-cycle sequencer that computes a WORDS×16-bit addition by time-sharing a single 16-bit `Ladner_Fischer_Exact` prefix adder instance. It processes one 16-bit slice per cycle and carries between slices through a register. Operands enter and results leave over valid/ready handshakes. It sits between the operand source (test harness or accumulator datapath) and the shared exact adder, letting wide additions reuse the 16-bit adder without replicating it.

---
 rtl/lf_multiword_add_seq.sv | 153 +++++++++++++++
 tb/tb_lf_multiword_add_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lf_multiword_add_seq.sv
// lf_multiword_add_seq: computes a WORDS x 16-bit addition by running one
// shared 16-bit Ladner-Fischer prefix adder over successive slices. A carry
// register links the slices. Operands and results use valid/ready handshakes.
// Optional build macro LF_SEQ_OVF_EN adds a registered signed-overflow flag.
// Without the macro, ovf is tied low.

// 16-bit exact parallel-prefix adder (Ladner-Fischer / Sklansky tree).
// Sum[16:1] is the 16-bit sum and Sum[17] is the carry out.
module Ladner_Fischer_Exact (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [17:1] Sum
);
  logic [16:0] c;

  // Level 0 holds per-bit generate/propagate.
  // After level l, node i covers group [i : (i>>l)<<l].
  // After level 4, every node covers [i:0].
  for (genvar l = 0; l <= 4; l++) begin : lvl
    logic [15:0] g;
    logic [15:0] p;
    if (l == 0) begin : base
      assign g = A & B;
      assign p = A ^ B;
    end else begin : merge
      for (genvar i = 0; i < 16; i++) begin : node
        if (((i >> (l - 1)) & 1) == 1) begin : join_blk
          localparam int J = ((i >> (l - 1)) << (l - 1)) - 1;
          assign g[i] = lvl[l-1].g[i] | (lvl[l-1].p[i] & lvl[l-1].g[J]);
          assign p[i] = lvl[l-1].p[i] & lvl[l-1].p[J];
        end else begin : pass_blk
          assign g[i] = lvl[l-1].g[i];
          assign p[i] = lvl[l-1].p[i];
        end
      end
    end
  end

  // The carry into bit i+1 is the group generate over [i:0],
  // plus the group propagate over [i:0] applied to Cin.
  assign c   = {lvl[4].g | (lvl[4].p & {16{Cin}}), Cin};
  assign Sum = {c[16], lvl[0].p ^ c[15:0]};
endmodule

module lf_multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*WORDS-1:0]  a,
  input  logic [16*WORDS-1:0]  b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*WORDS-1:0]  sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W  = 16 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry;
  logic [KW-1:0]   k;
  logic [KW+3:0]   shift;
  logic [15:0]     slice_a;
  logic [15:0]     slice_b;
  logic [17:1]     slice_res;
  logic [W-1:0]    slice_mask;
  logic [W-1:0]    slice_ins;

  assign in_ready = (state == IDLE) & ~rst;

  // Slice k occupies bits [16k+15:16k]. Shift by 16*k to select it.
  assign shift      = {k, 4'b0000};
  assign slice_a    = 16'(a_q >> shift);
  assign slice_b    = 16'(b_q >> shift);
  assign slice_mask = W'(16'hFFFF) << shift;
  assign slice_ins  = W'(slice_res[16:1]) << shift;

  Ladner_Fischer_Exact u_adder (
    .A   (slice_a),
    .B   (slice_b),
    .Cin (carry),
    .Sum (slice_res)
  );

  // Sequencer FSM: accept operands, ripple one slice per cycle, then hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      carry     <= 1'b0;
      k         <= '0;
`ifdef LF_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= (sum & ~slice_mask) | slice_ins;
          carry <= slice_res[17];
          if (k == K_LAST) begin
            cout      <= slice_res[17];
`ifdef LF_SEQ_OVF_EN
            // The carry into the MSB is a^b^sum at bit W-1.
            // Overflow is that carry XOR the carry out of the top slice.
            ovf       <= a_q[W-1] ^ b_q[W-1] ^ slice_res[16] ^ slice_res[17];
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef LF_SEQ_OVF_EN
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_lf_multiword_add_seq.sv
// Testbench for lf_multiword_add_seq.
// It uses two instances, WORDS=4 and WORDS=1. Expected results come from a
// plain-arithmetic model and are queued when an operand is accepted. Monitor
// processes compare every cycle that out_valid is high.
module tb_lf_multiword_add_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          iv4 = 1'b0, or4 = 1'b1, cin4 = 1'b0;
  logic          ir4, ov4, cout4, ovf4;
  logic [W-1:0]  a4 = '0, b4 = '0, sum4;

  logic          iv1 = 1'b0, or1 = 1'b1, cin1 = 1'b0;
  logic          ir1, ov1, cout1, ovf1;
  logic [15:0]   a1 = '0, b1 = '0, sum1;

  exp_t q4[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs4 = 0;
  logic ov4_prev = 1'b0;
  logic ov1_prev = 1'b0;
  bit   rnd_done = 1'b0;

  lf_multiword_add_seq #(.WORDS(WORDS)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4),
    .ovf(ovf4)
  );

  lf_multiword_add_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1),
    .ovf(ovf1)
  );

  always #5 clk = ~clk;

  // cyc is the number of rising edges so far.
  // The *_prev flags hold out_valid from the previous cycle.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ov4_prev <= ov4;
    ov1_prev <= ov1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: (a + b + cin) on nw bits.
  // cout is bit nw of the sum. Signed overflow means equal operand signs
  // but a different result sign.
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                 input logic c, input int nw);
    exp_t e;
    logic [64:0] full, m;
    m      = (65'd1 << nw) - 65'd1;
    full   = ({1'b0, x} & m) + ({1'b0, y} & m) + 65'(c);
    e.sum  = 64'(full & m);
    e.cout = 1'(full >> nw);
    e.ovf  = 1'b0;
`ifdef LF_SEQ_OVF_EN
    e.ovf  = (1'(x >> (nw - 1)) == 1'(y >> (nw - 1))) &&
             (1'(e.sum >> (nw - 1)) != 1'(x >> (nw - 1)));
`endif
    e.acc  = 0;
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Call at a negedge. An accept happens at the next rising edge when in_ready is high.
  // acc returns that edge's number.
  task automatic send4(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, output int acc);
    exp_t e;
    acc = -1;
    a4 = x; b4 = y; cin4 = c; iv4 = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (ir4) begin
        @(negedge clk);
        acc   = cyc;
        e     = model(x, y, c, W);
        e.acc = acc;
        q4.push_back(e);
        iv4 = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL w4_accept_timeout: got in_ready=0 for 100 cycles, required accept");
    iv4 = 1'b0;
  endtask

  task automatic send1(input logic [15:0] x, input logic [15:0] y,
                       input logic c, output int acc);
    exp_t e;
    acc = -1;
    a1 = x; b1 = y; cin1 = c; iv1 = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (ir1) begin
        @(negedge clk);
        acc   = cyc;
        e     = model({48'd0, x}, {48'd0, y}, c, 16);
        e.acc = acc;
        q1.push_back(e);
        iv1 = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL w1_accept_timeout: got in_ready=0 for 100 cycles, required accept");
    iv1 = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (q4.size() != 0 || q1.size() != 0); n++) @(negedge clk);
    checks++;
    if (q4.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got pending w4=%0d w1=%0d, required 0", q4.size(), q1.size());
    end
  endtask

  // Monitor for the WORDS=4 instance.
  // With accept edge t, out_valid must first be seen in cycle t+WORDS+1.
  // The cycle after edge n is cycle n+1.
  initial forever begin
    @(negedge clk);
    if (ov4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL w4_unexpected_out_valid: got out_valid=1, required 0 (no pending op)");
      end else begin
        if (!ov4_prev) chk("w4_latency", 65'(cyc + 1), 65'(q4[0].acc + WORDS + 1));
        chk("w4_sum",  65'(sum4),  65'(q4[0].sum));
        chk("w4_cout", 65'(cout4), 65'(q4[0].cout));
        chk("w4_ovf",  65'(ovf4),  65'(q4[0].ovf));
        chk("w4_in_ready_busy", 65'(ir4), 65'd0);
        if (or4) begin
          hs4 = cyc + 1;
          void'(q4.pop_front());
        end
      end
    end
  end

  // Monitor for the WORDS=1 instance.
  initial forever begin
    @(negedge clk);
    if (ov1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL w1_unexpected_out_valid: got out_valid=1, required 0 (no pending op)");
      end else begin
        if (!ov1_prev) chk("w1_latency", 65'(cyc + 1), 65'(q1[0].acc + 2));
        chk("w1_sum",  65'(sum1),  65'(q1[0].sum));
        chk("w1_cout", 65'(cout1), 65'(q1[0].cout));
        chk("w1_ovf",  65'(ovf1),  65'(q1[0].ovf));
        chk("w1_in_ready_busy", 65'(ir1), 65'd0);
        if (or1) void'(q1.pop_front());
      end
    end
  end

  initial begin
    int acc_a, acc_b, acc_prev;
    logic [W-1:0] x, y;

    // Reset state, checked while rst is still high.
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  65'(ir4),   65'd0);
    chk("rst_out_valid", 65'(ov4),   65'd0);
    chk("rst_sum",       65'(sum4),  65'd0);
    chk("rst_cout",      65'(cout4), 65'd0);
    chk("rst_ovf",       65'(ovf4),  65'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 65'(ir4), 65'd1);
    @(negedge clk);

    // Directed cases.
    send4(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, acc_a);
    drain();
    send4(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, acc_a);
    drain();
    send4(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, acc_a);
    drain();

    // Backpressure: the result is held while a second request waits.
    @(posedge clk); #1 or4 = 1'b0;
    @(negedge clk);
    send4(rnd64(), rnd64(), 1'b0, acc_a);
    x = rnd64(); y = rnd64();
    fork
      send4(x, y, 1'b1, acc_b);
      begin
        for (int n = 0; n < 50 && !ov4; n++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1 or4 = 1'b1;
      end
    join
    chk("w4_bp_accept_after_handshake", 65'(acc_b), 65'(hs4 + 1));
    drain();

    // Reset while slice 2 is in RUN. The operation is dropped.
    send4(rnd64(), rnd64(), 1'b0, acc_a);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q4.delete();
    chk("midrun_rst_out_valid", 65'(ov4),   65'd0);
    chk("midrun_rst_sum",       65'(sum4),  65'd0);
    chk("midrun_rst_cout",      65'(cout4), 65'd0);
    chk("midrun_rst_in_ready",  65'(ir4),   65'd0);
    rst = 1'b0;
    #1;
    chk("midrun_release_in_ready", 65'(ir4), 65'd1);
    @(negedge clk);
    send4(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, acc_a);
    drain();

    // Back-to-back with in_valid held high and out_ready=1: one accept every WORDS+2 edges.
    send4(rnd64(), rnd64(), 1'b0, acc_prev);
    for (int i = 0; i < 3; i++) begin
      send4(rnd64(), rnd64(), 1'($urandom_range(0, 1)), acc_b);
      chk("w4_b2b_spacing", 65'(acc_b - acc_prev), 65'(WORDS + 2));
      acc_prev = acc_b;
    end
    drain();

    // Randomized operands with random gaps and random out_ready.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          send4(rnd64(), rnd64(), 1'($urandom_range(0, 1)), acc_a);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 or4 = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1 or4 = 1'b1;
      end
    join
    drain();

    // WORDS=1 instance: single-cycle RUN, latency 2, one accept every 3 edges.
    @(negedge clk);
    send1(16'hFFFF, 16'h0001, 1'b0, acc_prev);
    for (int i = 0; i < 3; i++) begin
      send1(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), acc_b);
      chk("w1_b2b_spacing", 65'(acc_b - acc_prev), 65'd3);
      acc_prev = acc_b;
    end
    send1(16'h7FFF, 16'h0001, 1'b0, acc_a);
    send1(16'h8000, 16'h8000, 1'b0, acc_a);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
